bfly_pair_feeder: RTL and testbench

//  Input-side feeder for the first radix-2 butterfly/twiddle stage of the 512-pt FFT.

---
 rtl/bfly_pair_feeder.sv | 159 +++++++++++++++
 tb/tb_bfly_pair_feeder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bfly_pair_feeder.sv
// Input feeder for the first radix-2 FFT stage: buffers the first half-block of a
// 512-pt frame, then presents (x[n], x[n+256]) pairs to the butterfly one beat per cycle.
module bfly_pair_feeder #(
    parameter int N        = 8,
    parameter int IN_BIT   = 13,
    parameter int HALF_CYC = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din_valid,
    input  logic                  din_sof,
    input  logic [N*IN_BIT-1:0]   din_i,
    input  logic [N*IN_BIT-1:0]   din_q,
    output logic [N*IN_BIT-1:0]   dout1_i,
    output logic [N*IN_BIT-1:0]   dout1_q,
    output logic [N*IN_BIT-1:0]   dout2_i,
    output logic [N*IN_BIT-1:0]   dout2_q,
    output logic                  bfly_en,
    output logic                  blk_last,
    output logic                  err_seq
);

    localparam int LW = N * IN_BIT;
    localparam int WW = 2 * LW;
    localparam int CW = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF_CYC - 1);

    typedef enum logic {
        FILL,
        PAIR
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   cnt_next;

    logic            wr_en;
    logic [CW-1:0]   wr_addr;
    logic            pair_fire;
    logic            last_next;
    logic            err_next;

    // One word per beat holds all lanes, Q above I.
    logic [WW-1:0]   mem [HALF_CYC];
    logic [WW-1:0]   rd_word_reg;
    logic [WW-1:0]   live_word_reg;
    logic            bfly_en_reg;
    logic            blk_last_reg;
    logic            err_seq_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FILL;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wr_en      = 1'b0;
        wr_addr    = cnt_reg;
        pair_fire  = 1'b0;
        last_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            FILL: begin
                // With cnt==0 we are hunting: only a sof beat starts a block.
                if (din_valid && (din_sof || (cnt_reg != '0))) begin
                    wr_en    = 1'b1;
                    wr_addr  = din_sof ? '0 : cnt_reg;
                    err_next = din_sof && (cnt_reg != '0);
                    if (wr_addr == CNT_LAST) begin
                        state_next = PAIR;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = wr_addr + CW'(1);
                    end
                end
            end
            PAIR: begin
                if (!din_valid) begin
                    err_next   = 1'b1;
                    state_next = FILL;
                    cnt_next   = '0;
                end else if (din_sof) begin
                    // A premature sof restarts a block with this beat as x[0].
                    err_next = 1'b1;
                    wr_en    = 1'b1;
                    wr_addr  = '0;
                    if (CNT_LAST == '0) begin
                        state_next = PAIR;
                        cnt_next   = '0;
                    end else begin
                        state_next = FILL;
                        cnt_next   = CW'(1);
                    end
                end else begin
                    pair_fire = 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        last_next  = 1'b1;
                        state_next = FILL;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            default: begin
                state_next = FILL;
                cnt_next   = '0;
            end
        endcase
    end

    // Buffer is never cleared; its contents only matter after a full fill.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {din_q, din_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_word_reg <= '0;
        end else if (pair_fire) begin
            rd_word_reg <= mem[cnt_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_word_reg <= '0;
            bfly_en_reg   <= 1'b0;
            blk_last_reg  <= 1'b0;
            err_seq_reg   <= 1'b0;
        end else begin
            if (pair_fire) begin
                live_word_reg <= {din_q, din_i};
            end
            bfly_en_reg  <= pair_fire;
            blk_last_reg <= last_next;
            err_seq_reg  <= err_next;
        end
    end

    assign dout1_i  = rd_word_reg[LW-1:0];
    assign dout1_q  = rd_word_reg[WW-1:LW];
    assign dout2_i  = live_word_reg[LW-1:0];
    assign dout2_q  = live_word_reg[WW-1:LW];
    assign bfly_en  = bfly_en_reg;
    assign blk_last = blk_last_reg;
    assign err_seq  = err_seq_reg;

endmodule

// File: tb/tb_bfly_pair_feeder.sv
// Randomized and directed stimulus for bfly_pair_feeder, checked every cycle against
// a queue-based model of the block framing rules.
module tb_bfly_pair_feeder;

    localparam int N      = 8;
    localparam int IN_BIT = 13;
    localparam int HC     = 32;
    localparam int LW     = N * IN_BIT;

    logic          clk;
    logic          rst;
    logic          din_valid;
    logic          din_sof;
    logic [LW-1:0] din_i;
    logic [LW-1:0] din_q;
    logic [LW-1:0] dout1_i;
    logic [LW-1:0] dout1_q;
    logic [LW-1:0] dout2_i;
    logic [LW-1:0] dout2_q;
    logic          bfly_en;
    logic          blk_last;
    logic          err_seq;

    bfly_pair_feeder #(.N(N), .IN_BIT(IN_BIT), .HALF_CYC(HC)) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din_sof(din_sof),
        .din_i(din_i), .din_q(din_q),
        .dout1_i(dout1_i), .dout1_q(dout1_q), .dout2_i(dout2_i), .dout2_q(dout2_q),
        .bfly_en(bfly_en), .blk_last(blk_last), .err_seq(err_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int en_seen = 0;
    int err_seen = 0;
    int last_seen = 0;

    // Reference model: collected first-half beats in a queue.
    logic [2*LW-1:0] q[$];
    bit              pairing = 1'b0;
    logic            exp_en, exp_last, exp_err;
    logic [2*LW-1:0] exp_d1, exp_d2;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic s, input logic [2*LW-1:0] beat);
        if (r) begin
            q.delete();
            pairing = 1'b0;
            exp_en = 1'b0; exp_last = 1'b0; exp_err = 1'b0;
            exp_d1 = '0; exp_d2 = '0;
            return;
        end
        exp_en = 1'b0; exp_last = 1'b0; exp_err = 1'b0;
        if (!pairing) begin
            if (v && s) begin
                exp_err = (q.size() != 0);
                q.delete();
                q.push_back(beat);
            end else if (v && q.size() != 0) begin
                q.push_back(beat);
            end
            if (q.size() == HC) pairing = 1'b1;
        end else if (!v) begin
            exp_err = 1'b1;
            q.delete();
            pairing = 1'b0;
        end else if (s) begin
            exp_err = 1'b1;
            q.delete();
            q.push_back(beat);
            pairing = (q.size() == HC);
        end else begin
            exp_d1 = q.pop_front();
            exp_d2 = beat;
            exp_en = 1'b1;
            if (q.size() == 0) begin
                exp_last = 1'b1;
                pairing = 1'b0;
            end
        end
    endtask

    task automatic tick(input logic r, input logic v, input logic s, input logic [LW-1:0] di, input logic [LW-1:0] dq);
        rst = r; din_valid = v; din_sof = s; din_i = di; din_q = dq;
        model_step(r, v, s, {dq, di});
        @(negedge clk);
        check("bfly_en", 256'(bfly_en), 256'(exp_en));
        check("blk_last", 256'(blk_last), 256'(exp_last));
        check("err_seq", 256'(err_seq), 256'(exp_err));
        check("dout1", 256'({dout1_q, dout1_i}), 256'(exp_d1));
        check("dout2", 256'({dout2_q, dout2_i}), 256'(exp_d2));
        en_seen   += int'(bfly_en);
        err_seen  += int'(err_seq);
        last_seen += int'(blk_last);
    endtask

    function automatic logic [LW-1:0] rnd_vec();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[LW-1:0];
    endfunction

    function automatic logic [LW-1:0] nom_i(input int b);
        logic [LW-1:0] v;
        for (int l = 0; l < N; l++) v[l*IN_BIT +: IN_BIT] = 13'(b * N + l);
        return v;
    endfunction

    function automatic logic [LW-1:0] nom_q(input int b);
        logic [LW-1:0] v;
        for (int l = 0; l < N; l++) v[l*IN_BIT +: IN_BIT] = 13'(-(b * N + l));
        return v;
    endfunction

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) tick(1'b0, 1'b0, 1'b0, rnd_vec(), rnd_vec());
    endtask

    task automatic send_nom(input int b_first, input int count, input bit sof_first);
        for (int j = 0; j < count; j++)
            tick(1'b0, 1'b1, sof_first && (j == 0), nom_i(b_first + j), nom_q(b_first + j));
    endtask

    task automatic clear_counts();
        en_seen = 0; err_seen = 0; last_seen = 0;
    endtask

    initial begin
        // Reset with random inputs
        for (int j = 0; j < 2; j++)
            tick(1'b1, 1'($urandom), 1'($urandom), rnd_vec(), rnd_vec());
        check("rst_en", 256'(bfly_en), 256'(0));
        check("rst_d1", 256'({dout1_q, dout1_i}), 256'(0));

        // Nominal block
        clear_counts();
        send_nom(0, 64, 1'b1);
        check("t2_last", 256'(blk_last), 256'(1));
        check("t2_d1_l0", 256'(dout1_i[12:0]), 256'(13'd248));
        check("t2_d2_l7", 256'(dout2_i[7*IN_BIT +: IN_BIT]), 256'(13'd511));
        check("t2_d2q_l0", 256'(dout2_q[12:0]), 256'(13'h1e08));
        check("t2_en_cnt", 256'(en_seen), 256'(32));
        check("t2_err_cnt", 256'(err_seen), 256'(0));

        // Three back-to-back blocks
        clear_counts();
        for (int k = 0; k < 3; k++) send_nom(0, 64, 1'b1);
        check("t3_en_cnt", 256'(en_seen), 256'(96));
        check("t3_last_cnt", 256'(last_seen), 256'(3));
        check("t3_err_cnt", 256'(err_seen), 256'(0));

        // Gaps in FILL after beats 3 and 30
        clear_counts();
        send_nom(0, 4, 1'b1);
        idle(5);
        send_nom(4, 27, 1'b0);
        idle(5);
        send_nom(31, 33, 1'b0);
        check("t4_en_cnt", 256'(en_seen), 256'(32));
        check("t4_err_cnt", 256'(err_seen), 256'(0));

        // Gap in PAIR after 10 pairs, then stray beats, then a clean block
        clear_counts();
        send_nom(0, 42, 1'b1);
        idle(1);
        check("t5_err", 256'(err_seq), 256'(1));
        for (int j = 0; j < 4; j++) tick(1'b0, 1'b1, 1'b0, rnd_vec(), rnd_vec());
        send_nom(0, 64, 1'b1);
        check("t5_en_cnt", 256'(en_seen), 256'(42));
        check("t5_last_cnt", 256'(last_seen), 256'(1));
        check("t5_err_cnt", 256'(err_seen), 256'(1));

        // Early sof at beat 20, then reset in the middle of pairing
        for (int j = 0; j < 2; j++) tick(1'b1, 1'b0, 1'b0, rnd_vec(), rnd_vec());
        clear_counts();
        for (int j = 0; j < 5; j++) tick(1'b0, 1'b1, 1'b0, rnd_vec(), rnd_vec());
        send_nom(0, 20, 1'b1);
        send_nom(20, 32, 1'b1);
        send_nom(52, 1, 1'b0);
        check("t6_d1", 256'(dout1_i[12:0]), 256'(13'd160));
        send_nom(53, 14, 1'b0);
        tick(1'b1, 1'b1, 1'b0, rnd_vec(), rnd_vec());
        check("t6_rst_en", 256'(bfly_en), 256'(0));
        check("t6_rst_d2", 256'({dout2_q, dout2_i}), 256'(0));
        check("t6_en_cnt", 256'(en_seen), 256'(15));
        check("t6_err_cnt", 256'(err_seen), 256'(1));

        // Random blocks with occasional framing glitches
        for (int it = 0; it < 40; it++) begin
            int gpos;
            int gtype;
            gpos  = int'($urandom_range(63, 1));
            gtype = ($urandom_range(9, 0) < 3) ? int'($urandom_range(3, 1)) : 0;
            for (int j = 0; j < 64; j++) begin
                if (j < HC && j > 0 && $urandom_range(7, 0) == 0) idle(1);
                if (j == gpos && gtype == 1) idle(1);
                else if (j == gpos && gtype == 2) tick(1'b0, 1'b1, 1'b1, rnd_vec(), rnd_vec());
                else if (j == gpos && gtype == 3) tick(1'b1, 1'($urandom), 1'($urandom), rnd_vec(), rnd_vec());
                else tick(1'b0, 1'b1, (j == 0), rnd_vec(), rnd_vec());
            end
            idle(int'($urandom_range(3, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
